// File: rtl/slc3_mem_pkg.sv
// Shared types, defaults and helpers for the SLC-3 memory bridge.
package slc3_mem_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_RAM_AW     = 10;
  localparam int unsigned DEF_INIT_WORDS = 256;
  localparam int unsigned CPU_AW         = 16;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } bridge_state_t;

  // True when a CPU address falls inside a RAM of 2**aw words.
  function automatic logic in_range(input logic [CPU_AW-1:0] addr, input int unsigned aw);
    return (32'(addr) < (32'd1 << aw));
  endfunction

endpackage

// File: rtl/slc3_init_sequencer.sv
// Preload sequencer: walks the init ROM and turns each returned word into a RAM write
// one cycle later, flagging the last word and pulsing done while the final write drains.
module slc3_init_sequencer
  import slc3_mem_pkg::*;
#(
  parameter int unsigned RAM_AW     = DEF_RAM_AW,
  parameter int unsigned INIT_WORDS = DEF_INIT_WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_active,
  output logic [RAM_AW-1:0] o_rd_cnt,
  output logic              o_last_c,
  output logic              o_wr_valid,
  output logic [RAM_AW-1:0] o_wr_addr,
  output logic              o_done
);

  localparam int unsigned       LAST_WORD = (INIT_WORDS == 0) ? 0 : INIT_WORDS - 1;
  localparam logic [RAM_AW-1:0] LAST_CNT  = RAM_AW'(LAST_WORD);

  logic [RAM_AW-1:0] r_rd_cnt;
  logic              r_wr_valid;
  logic [RAM_AW-1:0] r_wr_addr;
  logic              r_done;

  assign o_rd_cnt   = r_rd_cnt;
  assign o_last_c   = (r_rd_cnt == LAST_CNT);
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_done     = r_done;

  // ROM data lags its address by one cycle, so the write address trails rd_cnt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_cnt   <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_wr_valid <= i_active;
      r_wr_addr  <= r_rd_cnt;
      r_done     <= i_active && o_last_c;
      if (i_active && !o_last_c) begin
        r_rd_cnt <= r_rd_cnt + RAM_AW'(1);
      end
    end
  end

endmodule

// File: rtl/slc3_mem_bridge.sv
// SLC-3 memory bridge: preloads RAM from ROM after reset, then serves CPU reads/writes.
// Optional write protection below WP_LIMIT is enabled by defining BRIDGE_WPROT_EN.
module slc3_mem_bridge
  import slc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RAM_AW     = DEF_RAM_AW,
  parameter int unsigned INIT_WORDS = DEF_INIT_WORDS,
  parameter logic [15:0] WP_LIMIT   = 16'h0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [DATA_W-1:0] Data_to_SRAM,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              CPU_Hold,
  output logic              Init_Done,
  output logic [RAM_AW-1:0] Rom_Addr,
  input  logic [DATA_W-1:0] Rom_Data,
  output logic [RAM_AW-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_Wdata,
  output logic              Ram_We,
  input  logic [DATA_W-1:0] Ram_Rdata,
  output logic              WP_Violation
);

`ifdef BRIDGE_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  bridge_state_t     r_state;
  logic              r_rd_pend;
  logic              r_rd_inr;
  logic              r_wp_viol;

  logic [RAM_AW-1:0] w_rd_cnt;
  logic              w_last_c;
  logic              w_wr_valid;
  logic [RAM_AW-1:0] w_wr_addr;
  logic              w_done;
  logic              w_seq_active;
  logic              w_run;
  logic              w_in_range;
  logic              w_wp_hit;
  logic              w_cpu_wr;
  logic              w_cpu_we;
  logic              w_cpu_rd;

  assign w_seq_active = (r_state == INIT) && (INIT_WORDS != 0);

  slc3_init_sequencer #(
    .RAM_AW     (RAM_AW),
    .INIT_WORDS (INIT_WORDS)
  ) u_seq (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_active   (w_seq_active),
    .o_rd_cnt   (w_rd_cnt),
    .o_last_c   (w_last_c),
    .o_wr_valid (w_wr_valid),
    .o_wr_addr  (w_wr_addr),
    .o_done     (w_done)
  );

  assign Rom_Addr     = w_rd_cnt;
  assign WP_Violation = r_wp_viol;

  assign w_run      = (r_state == RUN);
  assign w_in_range = in_range(ADDR, RAM_AW);
  assign w_wp_hit   = WPROT_EN && (ADDR < WP_LIMIT);
  assign w_cpu_wr   = w_run && !WE;
  assign w_cpu_we   = w_cpu_wr && w_in_range && !w_wp_hit;
  assign w_cpu_rd   = w_run && !OE && WE;

  // RAM port: preload pipeline until RUN, then the CPU; Reset kills any access in flight.
  always_comb begin
    Ram_Addr  = w_wr_addr;
    Ram_Wdata = Rom_Data;
    Ram_We    = w_wr_valid;
    if (w_run) begin
      Ram_Addr  = ADDR[RAM_AW-1:0];
      Ram_Wdata = Data_to_SRAM;
      Ram_We    = w_cpu_we;
    end
    if (Reset) begin
      Ram_We = 1'b0;
    end
  end

  // Bridge FSM plus read-capture and write-protect registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= INIT;
      CPU_Hold       <= 1'b1;
      Init_Done      <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_inr       <= 1'b0;
      r_wp_viol      <= 1'b0;
      Data_from_SRAM <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (INIT_WORDS == 0) begin
            r_state   <= RUN;
            CPU_Hold  <= 1'b0;
            Init_Done <= 1'b1;
          end else if (w_last_c) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_done) begin
            r_state   <= RUN;
            CPU_Hold  <= 1'b0;
            Init_Done <= 1'b1;
          end
        end
        RUN: r_state <= RUN;
        default: r_state <= INIT;
      endcase

      r_rd_pend <= w_cpu_rd;
      r_rd_inr  <= w_in_range;
      if (r_rd_pend) begin
        Data_from_SRAM <= r_rd_inr ? Ram_Rdata : '0;
      end
      if (w_cpu_wr && w_wp_hit) begin
        r_wp_viol <= 1'b1;
      end
    end
  end

endmodule
